// File: rtl/uart_change_streamer.sv
// Change-driven multi-channel UART telemetry transmitter.
// Samples CHANNELS words on a divided strobe. It marks channels whose value differs
// from the value last sent. Pending channels are granted round-robin, and each
// grant becomes one framed packet: header 0xA0|ch, payload MSB first, XOR checksum.
// The packet is sent over a single 8N1 line.
module uart_change_streamer #(
    parameter int DATA_W     = 32,
    parameter int CHANNELS   = 2,
    parameter int CLK_DIV    = 434,
    parameter int SAMPLE_DIV = 4,
    parameter int REFRESH    = 0
) (
    input  logic                       Clk,
    input  logic                       rst,
    input  logic [CHANNELS*DATA_W-1:0] i_data,
    input  logic                       i_enable,
    output logic                       o_uart_tx,
    output logic                       o_busy,
    output logic                       o_overrun
);

    localparam int NBYTES = DATA_W / 8;
    localparam int PTR_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int BAUD_W = $clog2(CLK_DIV);
    localparam int SDIV_W = $clog2(SAMPLE_DIV);
    localparam int REF_W  = (REFRESH > 1) ? $clog2(REFRESH) : 1;
    localparam int BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [1:0] F_IDLE = 2'd0, F_HDR = 2'd1, F_PAY = 2'd2, F_CSUM = 2'd3;
    localparam logic [1:0] B_IDLE = 2'd0, B_START = 2'd1, B_DATA = 2'd2, B_STOP = 2'd3;

    logic [SDIV_W-1:0]  sample_cnt;
    logic [REF_W-1:0]   ref_cnt;
    logic               strobe, refresh_hit;
    logic               cmp_valid, refresh_due;
    logic [DATA_W-1:0]  sample    [CHANNELS];
    logic [DATA_W-1:0]  last_sent [CHANNELS];
    logic [CHANNELS-1:0] sample_chg, pending, set_vec, grant_hit;
    logic               overrun_now;
    logic [PTR_W-1:0]   rr_ptr, grant_idx;
    logic               grant_valid;
    logic [7:0]         hdr;

    logic [1:0]         frame_state, bit_state;
    logic [BAUD_W-1:0]  baud_cnt;
    logic [2:0]         bit_idx;
    logic [BYTE_W-1:0]  byte_cnt;
    logic [DATA_W-1:0]  snap;
    logic [7:0]         tx_byte, csum;

    assign strobe      = (sample_cnt == SDIV_W'(SAMPLE_DIV - 1));
    assign refresh_hit = (REFRESH != 0) && strobe && (ref_cnt == REF_W'(REFRESH - 1));
    assign hdr         = 8'hA0 | {4'h0, 4'(grant_idx)};
    assign o_busy      = (frame_state != F_IDLE);

    // Free-running sample divider and refresh strobe counter.
    // NOTE: every register updated in always_ff uses <= so all state advances from pre-edge values.
    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            sample_cnt <= '0;
            ref_cnt    <= '0;
        end else begin
            sample_cnt <= strobe ? '0 : sample_cnt + SDIV_W'(1);
            if (strobe) ref_cnt <= refresh_hit ? '0 : ref_cnt + REF_W'(1);
        end
    end

    // Round-robin arbiter: lowest pending index at or after rr_ptr, only while the framer is idle.
    // NOTE: outputs get defaults before any conditional so no latch is inferred.
    always_comb begin
        int idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        if (frame_state == F_IDLE) begin
            for (int i = CHANNELS - 1; i >= 0; i--) begin
                idx = int'(rr_ptr) + i;
                if (idx >= CHANNELS) idx = idx - CHANNELS;
                if (pending[idx]) begin
                    grant_valid = 1'b1;
                    grant_idx   = PTR_W'(idx);
                end
            end
        end
    end

    // Per-channel pending set and overrun detection for the cycle after a strobe.
    // A channel granted this cycle compares equal to its own last_sent update, so only refresh can re-arm it.
    always_comb begin
        overrun_now = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            grant_hit[k] = grant_valid && (grant_idx == PTR_W'(k));
            set_vec[k]   = cmp_valid && i_enable &&
                           (refresh_due || ((sample[k] != last_sent[k]) && !grant_hit[k]));
            if (cmp_valid && pending[k] && sample_chg[k] && !grant_hit[k]) overrun_now = 1'b1;
        end
    end

    // Sample capture, change tracking, pending flags and round-robin pointer.
    // NOTE: sample/last_sent arrays are reset because a zero last_sent defines what counts as "changed" after reset.
    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < CHANNELS; k++) begin
                sample[k]    <= '0;
                last_sent[k] <= '0;
            end
            sample_chg  <= '0;
            pending     <= '0;
            cmp_valid   <= 1'b0;
            refresh_due <= 1'b0;
            rr_ptr      <= '0;
            o_overrun   <= 1'b0;
        end else begin
            cmp_valid   <= strobe;
            refresh_due <= refresh_hit;
            o_overrun   <= overrun_now;
            pending     <= (pending & ~grant_hit) | set_vec;
            for (int k = 0; k < CHANNELS; k++) begin
                sample_chg[k] <= strobe && (i_data[k*DATA_W +: DATA_W] != sample[k]);
                if (strobe) sample[k] <= i_data[k*DATA_W +: DATA_W];
                if (grant_hit[k]) last_sent[k] <= sample[k];
            end
            if (grant_valid)
                rr_ptr <= (grant_idx == PTR_W'(CHANNELS - 1)) ? '0 : grant_idx + PTR_W'(1);
        end
    end

    // Frame and bit sequencer: bytes run back-to-back; the line idles high between frames.
    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            frame_state <= F_IDLE;
            bit_state   <= B_IDLE;
            baud_cnt    <= '0;
            bit_idx     <= '0;
            byte_cnt    <= '0;
            snap        <= '0;
            tx_byte     <= '0;
            csum        <= '0;
            o_uart_tx   <= 1'b1;
        end else if (bit_state == B_IDLE) begin
            if (grant_valid) begin
                frame_state <= F_HDR;
                bit_state   <= B_START;
                baud_cnt    <= '0;
                tx_byte     <= hdr;
                csum        <= hdr;
                snap        <= sample[grant_idx];
                o_uart_tx   <= 1'b0;
            end
        end else if (baud_cnt != BAUD_W'(CLK_DIV - 1)) begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
        end else begin
            baud_cnt <= '0;
            case (bit_state)
                B_START: begin
                    bit_state <= B_DATA;
                    bit_idx   <= '0;
                    o_uart_tx <= tx_byte[0];
                    tx_byte   <= tx_byte >> 1;
                end
                B_DATA: begin
                    if (bit_idx == 3'd7) begin
                        bit_state <= B_STOP;
                        o_uart_tx <= 1'b1;
                    end else begin
                        bit_idx   <= bit_idx + 3'd1;
                        o_uart_tx <= tx_byte[0];
                        tx_byte   <= tx_byte >> 1;
                    end
                end
                B_STOP: begin
                    if (frame_state == F_CSUM) begin
                        frame_state <= F_IDLE;
                        bit_state   <= B_IDLE;
                    end else begin
                        bit_state <= B_START;
                        o_uart_tx <= 1'b0;
                        if (frame_state == F_PAY && byte_cnt == BYTE_W'(NBYTES - 1)) begin
                            frame_state <= F_CSUM;
                            tx_byte     <= csum;
                        end else begin
                            frame_state <= F_PAY;
                            byte_cnt    <= (frame_state == F_HDR) ? '0 : byte_cnt + BYTE_W'(1);
                            tx_byte     <= snap[DATA_W-1 -: 8];
                            csum        <= csum ^ snap[DATA_W-1 -: 8];
                            snap        <= snap << 8;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_change_streamer.sv
// Directed bench for uart_change_streamer: reset idle, single and simultaneous
// changes, coalescing/overrun, mid-frame reset, enable gating and forced refresh.
// Frames are captured cycle by cycle and compared against hand-computed byte lists.
module tb_uart_change_streamer;

    localparam int DATA_W     = 32;
    localparam int CHANNELS   = 2;
    localparam int CLK_DIV    = 8;
    localparam int SAMPLE_DIV = 4;
    localparam int FRAME_CYC  = 10 * CLK_DIV * (DATA_W / 8 + 2);

    logic                       Clk = 1'b0;
    logic                       rst, rst_r;
    logic [CHANNELS*DATA_W-1:0] data_a, data_r;
    logic                       en_a, en_r;
    logic                       tx_a, busy_a, ovr_a;
    logic                       tx_r, busy_r, ovr_r;

    int checks  = 0;
    int errors  = 0;
    int ovr_cnt = 0;

    always #5 Clk = ~Clk;

    uart_change_streamer #(
        .DATA_W(DATA_W), .CHANNELS(CHANNELS), .CLK_DIV(CLK_DIV),
        .SAMPLE_DIV(SAMPLE_DIV), .REFRESH(0)
    ) u_dut_a (
        .Clk(Clk), .rst(rst), .i_data(data_a), .i_enable(en_a),
        .o_uart_tx(tx_a), .o_busy(busy_a), .o_overrun(ovr_a)
    );

    uart_change_streamer #(
        .DATA_W(DATA_W), .CHANNELS(CHANNELS), .CLK_DIV(CLK_DIV),
        .SAMPLE_DIV(SAMPLE_DIV), .REFRESH(3)
    ) u_dut_r (
        .Clk(Clk), .rst(rst_r), .i_data(data_r), .i_enable(en_r),
        .o_uart_tx(tx_r), .o_busy(busy_r), .o_overrun(ovr_r)
    );

    // Counts overrun pulses seen on the main instance.
    always @(negedge Clk) if (ovr_a === 1'b1) ovr_cnt++;

    function automatic logic tx_of(input bit sel);
        return sel ? tx_r : tx_a;
    endfunction

    function automatic logic busy_of(input bit sel);
        return sel ? busy_r : busy_a;
    endfunction

    // Waits (bounded) for a frame to start, captures it cycle by cycle, and checks
    // the exact waveform, the busy window, and the line state after the frame.
    task automatic expect_frame(input bit sel, input logic [47:0] expv,
                                input int timeout, input string name);
        logic        cap_tx   [FRAME_CYC];
        logic        cap_busy [FRAME_CYC];
        logic [47:0] got;
        logic        exp_bit;
        int          waited, bad, bi, pos;
        waited = 0;
        while (busy_of(sel) !== 1'b1 && waited < timeout) begin
            @(negedge Clk);
            waited++;
        end
        checks++;
        if (busy_of(sel) !== 1'b1) begin
            errors++;
            $display("FAIL %s start: o_busy=%b after %0d cycles, expected 1", name, busy_of(sel), waited);
            return;
        end
        for (int c = 0; c < FRAME_CYC; c++) begin
            cap_tx[c]   = tx_of(sel);
            cap_busy[c] = busy_of(sel);
            @(negedge Clk);
        end
        got = '0;
        for (int i = 0; i < 6; i++)
            for (int b = 0; b < 8; b++)
                got[40 - 8*i + b] = cap_tx[(i*10 + 1 + b) * CLK_DIV + CLK_DIV/2];
        bad = -1;
        for (int c = 0; c < FRAME_CYC; c++) begin
            bi  = c / (10 * CLK_DIV);
            pos = (c / CLK_DIV) % 10;
            if (pos == 0)      exp_bit = 1'b0;
            else if (pos == 9) exp_bit = 1'b1;
            else               exp_bit = expv[40 - 8*bi + pos - 1];
            if (bad < 0 && (cap_tx[c] !== exp_bit || cap_busy[c] !== 1'b1)) bad = c;
        end
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s wave: first bad cycle %0d (tx=%b busy=%b), decoded %h, expected %h",
                     name, bad, cap_tx[bad], cap_busy[bad], got, expv);
        end
        checks++;
        if (busy_of(sel) !== 1'b0 || tx_of(sel) !== 1'b1) begin
            errors++;
            $display("FAIL %s end: busy=%b tx=%b after %0d cycles, expected busy=0 tx=1",
                     name, busy_of(sel), tx_of(sel), FRAME_CYC);
        end
    endtask

    task automatic test_reset();
        int tx_bad, busy_bad, ovr_bad;
        tx_bad = 0; busy_bad = 0; ovr_bad = 0;
        rst = 1'b0; rst_r = 1'b0;
        en_a = 1'b1; en_r = 1'b1;
        data_a = '0;
        data_r = {32'h0000_0000, 32'h1122_3344};
        repeat (20) @(negedge Clk);
        rst = 1'b1;
        repeat (1000) begin
            @(negedge Clk);
            if (tx_a !== 1'b1)   tx_bad++;
            if (busy_a !== 1'b0) busy_bad++;
            if (ovr_a !== 1'b0)  ovr_bad++;
        end
        checks++;
        if (tx_bad != 0) begin errors++; $display("FAIL reset tx: %0d cycles not high, expected 0", tx_bad); end
        checks++;
        if (busy_bad != 0) begin errors++; $display("FAIL reset busy: %0d cycles high, expected 0", busy_bad); end
        checks++;
        if (ovr_bad != 0) begin errors++; $display("FAIL reset overrun: %0d pulses, expected 0", ovr_bad); end
    endtask

    task automatic test_both_same_strobe();
        data_a = {32'h0000_0002, 32'h0000_0001};
        expect_frame(1'b0, 48'hA0_00000001_A1, 20, "both ch0");
        expect_frame(1'b0, 48'hA1_00000002_A3, 20, "both ch1");
        checks++;
        if (u_dut_a.rr_ptr !== '0) begin
            errors++;
            $display("FAIL both rr_ptr: got %0d, expected 0", u_dut_a.rr_ptr);
        end
    endtask

    task automatic test_single();
        data_a[31:0] = 32'h1234_5678;
        expect_frame(1'b0, 48'hA0_12345678_A8, 20, "single ch0");
    endtask

    task automatic test_overrun();
        int base, busy_seen;
        base = ovr_cnt;
        busy_seen = 0;
        data_a[31:0] = 32'h0000_0003;
        fork
            expect_frame(1'b0, 48'hA0_00000003_A3, 20, "ovr ch0");
            begin
                repeat (40) @(negedge Clk);
                data_a[63:32] = 32'h0000_0005;
                repeat (12) @(negedge Clk);
                data_a[63:32] = 32'h0000_0006;
            end
        join
        expect_frame(1'b0, 48'hA1_00000006_A7, 20, "ovr ch1");
        checks++;
        if (ovr_cnt - base != 1) begin
            errors++;
            $display("FAIL overrun count: got %0d pulses, expected 1", ovr_cnt - base);
        end
        repeat (200) begin
            @(negedge Clk);
            if (busy_a !== 1'b0) busy_seen++;
        end
        checks++;
        if (busy_seen != 0) begin
            errors++;
            $display("FAIL overrun extra frame: busy high %0d cycles, expected 0", busy_seen);
        end
    endtask

    task automatic test_reset_midframe();
        int waited;
        waited = 0;
        data_a[31:0] = 32'h0000_0009;
        while (busy_a !== 1'b1 && waited < 20) begin
            @(negedge Clk);
            waited++;
        end
        repeat (180) @(negedge Clk);
        checks++;
        if (tx_a !== 1'b0) begin
            errors++;
            $display("FAIL midframe payload bit: tx=%b busy=%b, expected tx=0 busy=1", tx_a, busy_a);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (tx_a !== 1'b1) begin errors++; $display("FAIL async reset tx: got %b, expected 1", tx_a); end
        checks++;
        if (busy_a !== 1'b0) begin errors++; $display("FAIL async reset busy: got %b, expected 0", busy_a); end
        repeat (5) @(negedge Clk);
        rst = 1'b1;
        expect_frame(1'b0, 48'hA0_00000009_A9, 20, "resend ch0");
        expect_frame(1'b0, 48'hA1_00000006_A7, 20, "resend ch1");
    endtask

    task automatic test_enable();
        int busy_seen;
        busy_seen = 0;
        en_a = 1'b0;
        data_a[31:0] = 32'h0000_000A;
        repeat (100) begin
            @(negedge Clk);
            if (busy_a !== 1'b0) busy_seen++;
        end
        checks++;
        if (busy_seen != 0) begin
            errors++;
            $display("FAIL enable low: busy high %0d cycles, expected 0", busy_seen);
        end
        en_a = 1'b1;
        expect_frame(1'b0, 48'hA0_0000000A_AA, 2 * SAMPLE_DIV + 2, "enable frame");
    endtask

    task automatic test_refresh();
        rst_r = 1'b1;
        expect_frame(1'b1, 48'hA0_11223344_E4, 20, "refresh ch0 a");
        expect_frame(1'b1, 48'hA1_00000000_A1, 20, "refresh ch1 a");
        expect_frame(1'b1, 48'hA0_11223344_E4, 20, "refresh ch0 b");
        expect_frame(1'b1, 48'hA1_00000000_A1, 20, "refresh ch1 b");
    endtask

    initial begin
        test_reset();
        test_both_same_strobe();
        test_single();
        test_overrun();
        test_reset_midframe();
        test_enable();
        test_refresh();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop in case any bounded wait above is defeated.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
